// File: rtl/calendar_counter_if.sv
// Calendar counter bus: tick/button inputs and registered date outputs.
//   master : drives tick, inc, dec; observes date, leap, dim, wrap (and dow)
//   slave  : the calendar_counter side
// dow exists only when CALENDAR_COUNTER_DOW_EN is defined.
interface calendar_counter_if #(
   parameter int unsigned YW = 14
);
   logic          tick;
   logic [2:0]    inc;
   logic [2:0]    dec;
   logic [4:0]    day;
   logic [3:0]    month;
   logic [YW-1:0] year;
   logic          leap;
   logic [4:0]    dim;
   logic          wrap;
`ifdef CALENDAR_COUNTER_DOW_EN
   logic [2:0]    dow;
`endif

   modport master (
      output tick, inc, dec,
      input
`ifdef CALENDAR_COUNTER_DOW_EN
      dow,
`endif
      day, month, year, leap, dim, wrap
   );

   modport slave (
      input tick, inc, dec,
      output
`ifdef CALENDAR_COUNTER_DOW_EN
      dow,
`endif
      day, month, year, leap, dim, wrap
   );
endinterface

// File: rtl/calendar_counter.sv
// Gregorian calendar counter with day tick and release-triggered
// increment/decrement buttons for {year, month, day}.
//   clk  : rising-edge clock
//   rst  : asynchronous active-low reset to RST_YEAR-RST_MONTH-RST_DAY
//   cal  : calendar_counter_if.slave (tick, inc, dec in; day, month,
//          year, leap, dim, wrap out, all registered)
// Optional macro CALENDAR_COUNTER_DOW_EN adds a day-of-week output (dow,
// 0=Sunday) and parameter RST_DOW.
module calendar_counter #(
   parameter int unsigned YEAR_MIN  = 1,
   parameter int unsigned YEAR_MAX  = 9999,
   parameter int unsigned YW        = 14,
   parameter int unsigned RST_YEAR  = 2018,
   parameter int unsigned RST_MONTH = 12,
   parameter int unsigned RST_DAY   = 5
`ifdef CALENDAR_COUNTER_DOW_EN
   ,
   parameter int unsigned RST_DOW   = 3
`endif
) (
   input  logic                clk,
   input  logic                rst,
   calendar_counter_if.slave   cal
);

   localparam logic [YW-1:0] Y_MIN = YW'(YEAR_MIN);
   localparam logic [YW-1:0] Y_MAX = YW'(YEAR_MAX);
   localparam logic [YW-1:0] Y_RST = YW'(RST_YEAR);
   localparam logic [3:0]    M_RST = 4'(RST_MONTH);
   localparam logic [4:0]    D_RST = 5'(RST_DAY);

   // Gregorian leap-year rule
   function automatic logic is_leap(input logic [YW-1:0] y);
      int unsigned v;
      v = 32'(y);
      return (v % 4 == 0) && ((v % 100 != 0) || (v % 400 == 0));
   endfunction

   // Month length for a given month and leap flag
   function automatic logic [4:0] days_in(input logic [3:0] m, input logic lp);
      case (m)
         4'd2:                     return lp ? 5'd29 : 5'd28;
         4'd4, 4'd6, 4'd9, 4'd11:  return 5'd30;
         default:                  return 5'd31;
      endcase
   endfunction

   logic [4:0]    day_q, day_n;
   logic [3:0]    month_q, month_n;
   logic [YW-1:0] year_q, year_n;
   logic          leap_q, leap_n;
   logic [4:0]    dim_q, dim_n;
   logic          wrap_q, wrap_n;
   logic          adj;

   // Button history; a bit is armed only after it has been seen low since
   // reset, so a button held through reset cannot fire on its first release.
   logic [2:0]    inc_q, dec_q, inc_arm, dec_arm;
   logic [2:0]    rel_inc, rel_dec;

   assign rel_inc = inc_q & ~cal.inc & inc_arm;
   assign rel_dec = dec_q & ~cal.dec & dec_arm;

   // Next date: tick beats any release; one adjust per cycle by priority
   always_comb begin
      day_n   = day_q;
      month_n = month_q;
      year_n  = year_q;
      wrap_n  = 1'b0;
      adj     = 1'b0;
      leap_n  = leap_q;
      dim_n   = dim_q;

      if (cal.tick) begin
         if (day_q < dim_q) begin
            day_n = day_q + 5'd1;
         end else begin
            day_n = 5'd1;
            if (month_q == 4'd12) begin
               month_n = 4'd1;
               if (year_q == Y_MAX) begin
                  year_n = Y_MIN;
                  wrap_n = 1'b1;
               end else begin
                  year_n = year_q + YW'(1);
               end
            end else begin
               month_n = month_q + 4'd1;
            end
         end
      end else if (rel_inc[2]) begin
         adj    = 1'b1;
         year_n = (year_q == Y_MAX) ? Y_MIN : year_q + YW'(1);
      end else if (rel_dec[2]) begin
         adj    = 1'b1;
         year_n = (year_q == Y_MIN) ? Y_MAX : year_q - YW'(1);
      end else if (rel_inc[1]) begin
         adj     = 1'b1;
         month_n = (month_q == 4'd12) ? 4'd1 : month_q + 4'd1;
      end else if (rel_dec[1]) begin
         adj     = 1'b1;
         month_n = (month_q == 4'd1) ? 4'd12 : month_q - 4'd1;
      end else if (rel_inc[0]) begin
         adj   = 1'b1;
         day_n = (day_q >= dim_q) ? 5'd1 : day_q + 5'd1;
      end else if (rel_dec[0]) begin
         adj   = 1'b1;
         day_n = (day_q <= 5'd1) ? dim_q : day_q - 5'd1;
      end

      leap_n = is_leap(year_n);
      dim_n  = days_in(month_n, leap_n);
      // Clamp after a month/year change shortened the month
      if (day_n > dim_n) begin
         day_n = dim_n;
      end
   end

   // Date, flags and button history registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         day_q   <= D_RST;
         month_q <= M_RST;
         year_q  <= Y_RST;
         leap_q  <= is_leap(Y_RST);
         dim_q   <= days_in(M_RST, is_leap(Y_RST));
         wrap_q  <= 1'b0;
         inc_q   <= 3'b000;
         dec_q   <= 3'b000;
         inc_arm <= 3'b000;
         dec_arm <= 3'b000;
      end else begin
         day_q   <= day_n;
         month_q <= month_n;
         year_q  <= year_n;
         leap_q  <= leap_n;
         dim_q   <= dim_n;
         wrap_q  <= wrap_n;
         inc_q   <= cal.inc;
         dec_q   <= cal.dec;
         inc_arm <= inc_arm | ~cal.inc;
         dec_arm <= dec_arm | ~cal.dec;
      end
   end

   assign cal.day   = day_q;
   assign cal.month = month_q;
   assign cal.year  = year_q;
   assign cal.leap  = leap_q;
   assign cal.dim   = dim_q;
   assign cal.wrap  = wrap_q;

`ifdef CALENDAR_COUNTER_DOW_EN
   // Day of week from a date (Sakamoto), 0 = Sunday
   function automatic logic [2:0] dow_of(input logic [4:0] d, input logic [3:0] m,
                                         input logic [YW-1:0] y);
      int unsigned yy;
      int unsigned t;
      yy = 32'(y);
      if (m < 4'd3) yy = yy - 1;
      case (m)
         4'd1:    t = 0;
         4'd2:    t = 3;
         4'd3:    t = 2;
         4'd4:    t = 5;
         4'd5:    t = 0;
         4'd6:    t = 3;
         4'd7:    t = 5;
         4'd8:    t = 1;
         4'd9:    t = 4;
         4'd10:   t = 6;
         4'd11:   t = 2;
         default: t = 4;
      endcase
      return 3'((yy + yy / 4 - yy / 100 + yy / 400 + t + 32'(d)) % 7);
   endfunction

   logic [2:0] dow_q, dow_n, dow_base;
   logic       recalc_q;

   // Adjusts schedule a recompute from the registered date one cycle later
   always_comb begin
      dow_base = recalc_q ? dow_of(day_q, month_q, year_q) : dow_q;
      dow_n    = dow_base;
      if (cal.tick) begin
         dow_n = (dow_base == 3'd6) ? 3'd0 : dow_base + 3'd1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         dow_q    <= 3'(RST_DOW);
         recalc_q <= 1'b0;
      end else begin
         dow_q    <= dow_n;
         recalc_q <= adj;
      end
   end

   assign cal.dow = dow_q;
`endif

endmodule

// File: tb/tb_calendar_counter.sv
// Self-checking bench for calendar_counter: a date-level reference model
// checked every cycle, plus hand-computed literal expectations.
module tb_calendar_counter;
   localparam int YMIN = 1;
   localparam int YMAX = 9999;
   localparam int NY   = YMAX - YMIN + 1;

   logic clk;
   logic rst;
   int   checks = 0;
   int   errors = 0;
   bit   chk_en = 0;

   calendar_counter_if #(.YW(14)) bus ();

   calendar_counter dut (
      .clk (clk),
      .rst (rst),
      .cal (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model state
   int       m_day, m_month, m_year, m_dow;
   bit       m_wrap, m_dow_pend;
   bit [2:0] m_prev_inc, m_prev_dec, m_seen0_inc, m_seen0_dec;

   function automatic bit mleap(input int y);
      return (y % 4 == 0) && ((y % 100 != 0) || (y % 400 == 0));
   endfunction

   function automatic int mdim(input int y, input int m);
      int tbl[12] = '{31, 28, 31, 30, 31, 30, 31, 31, 30, 31, 30, 31};
      if (m == 2 && mleap(y)) return 29;
      return tbl[m-1];
   endfunction

   // Day count from 0001-01-01 (a Monday) modulo 7
   function automatic int mdow(input int y, input int m, input int d);
      int n;
      n = 365 * (y - 1) + (y - 1) / 4 - (y - 1) / 100 + (y - 1) / 400;
      for (int k = 1; k < m; k++) n += mdim(y, k);
      n += d;
      return n % 7;
   endfunction

   task automatic check(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_day = 5; m_month = 12; m_year = 2018; m_dow = 3;
      m_wrap = 0; m_dow_pend = 0;
      m_prev_inc = 0; m_prev_dec = 0; m_seen0_inc = 0; m_seen0_dec = 0;
   endtask

   task automatic model_clk(input bit t, input bit [2:0] i, input bit [2:0] d);
      bit [2:0] ri, rd;
      bit adj;
      int dm;
      if (!rst) return;
      ri = m_prev_inc & ~i & m_seen0_inc;
      rd = m_prev_dec & ~d & m_seen0_dec;
      m_wrap = 0;
      adj = 0;
      if (m_dow_pend) m_dow = mdow(m_year, m_month, m_day);
      m_dow_pend = 0;
      dm = mdim(m_year, m_month);
      if (t) begin
         m_dow = (m_dow + 1) % 7;
         if (m_day < dm) m_day++;
         else begin
            m_day = 1;
            if (m_month == 12) begin
               m_month = 1;
               if (m_year == YMAX) begin m_year = YMIN; m_wrap = 1; end
               else m_year++;
            end else m_month++;
         end
      end else begin
         adj = 1;
         if      (ri[2]) m_year  = (m_year - YMIN + 1) % NY + YMIN;
         else if (rd[2]) m_year  = (m_year - YMIN + NY - 1) % NY + YMIN;
         else if (ri[1]) m_month = m_month % 12 + 1;
         else if (rd[1]) m_month = (m_month + 10) % 12 + 1;
         else if (ri[0]) m_day   = m_day % dm + 1;
         else if (rd[0]) m_day   = (m_day + dm - 2) % dm + 1;
         else adj = 0;
      end
      if (adj) begin
         m_dow_pend = 1;
         if (m_day > mdim(m_year, m_month)) m_day = mdim(m_year, m_month);
      end
      m_prev_inc = i; m_prev_dec = d;
      m_seen0_inc |= ~i; m_seen0_dec |= ~d;
   endtask

   // Per-cycle comparison against the model
   always @(negedge clk) begin
      if (chk_en && rst) begin
         check("day",   int'(bus.day),   m_day);
         check("month", int'(bus.month), m_month);
         check("year",  int'(bus.year),  m_year);
         check("leap",  int'(bus.leap),  int'(mleap(m_year)));
         check("dim",   int'(bus.dim),   mdim(m_year, m_month));
         check("wrap",  int'(bus.wrap),  int'(m_wrap));
`ifdef CALENDAR_COUNTER_DOW_EN
         check("dow",   int'(bus.dow),   m_dow);
`endif
      end
   end

   // One clock: drive inputs, advance the model at the edge, return after negedge
   task automatic step(input bit t, input bit [2:0] i, input bit [2:0] d);
      bus.tick = t; bus.inc = i; bus.dec = d;
      @(posedge clk);
      model_clk(t, i, d);
      @(negedge clk);
   endtask

   task automatic press(input int b, input bit up);
      bit [2:0] msk;
      msk = 3'(1 << b);
      if (up) step(0, msk, 3'b000);
      else    step(0, 3'b000, msk);
      step(0, 3'b000, 3'b000);
   endtask

   task automatic set_date(input int y, input int m, input int d);
      while (m_year != y)
         press(2, ((y - m_year + NY) % NY) <= NY / 2);
      while (m_month != m)
         press(1, ((m - m_month + 12) % 12) <= 6);
      while (m_day != d)
         press(0, d > m_day);
   endtask

   task automatic check_date(input string nm, input int y, input int m, input int d);
      check({nm, ".year"},  int'(bus.year),  y);
      check({nm, ".month"}, int'(bus.month), m);
      check({nm, ".day"},   int'(bus.day),   d);
   endtask

   initial begin
      rst = 1'b0;
      bus.tick = 1'b0; bus.inc = 3'b001; bus.dec = 3'b000;
      model_reset();
      #12;
      // Reset state, with inc-day held through reset
      check_date("reset", 2018, 12, 5);
      check("reset.leap", int'(bus.leap), 0);
      check("reset.dim",  int'(bus.dim), 31);
      check("reset.wrap", int'(bus.wrap), 0);
      rst = 1'b1;
      chk_en = 1;
      step(0, 3'b001, 3'b000);
      step(0, 3'b001, 3'b000);
      step(0, 3'b000, 3'b000);
      check("held_thru_reset.day", int'(bus.day), 5);
      press(0, 1);
      check("inc_day", int'(bus.day), 6);
      press(0, 0);
      check("dec_day", int'(bus.day), 5);

      // 27 ticks to the new year
      for (int k = 0; k < 27; k++) step(1, 3'b000, 3'b000);
      check_date("ticks27", 2019, 1, 1);
      check("ticks27.wrap", int'(bus.wrap), 0);

      // Tick beats a coincident release
      step(0, 3'b001, 3'b000);
      step(1, 3'b000, 3'b000);
      check_date("tick_vs_rel", 2019, 1, 2);
      // Month inc beats day dec
      step(0, 3'b010, 3'b001);
      step(0, 3'b000, 3'b000);
      check_date("mon_vs_day", 2019, 2, 2);

      // Leap rollovers
      set_date(2000, 2, 28);
      step(1, 3'b000, 3'b000);
      check_date("y2000", 2000, 2, 29);
      check("y2000.dim", int'(bus.dim), 29);
      set_date(1900, 2, 28);
      step(1, 3'b000, 3'b000);
      check_date("y1900", 1900, 3, 1);
      set_date(2100, 2, 28);
      step(1, 3'b000, 3'b000);
      check_date("y2100", 2100, 3, 1);

      // Clamp on month and year adjust
      set_date(2020, 3, 31);
      press(1, 0);
      check_date("clamp_month", 2020, 2, 29);
      press(2, 0);
      check_date("clamp_year", 2019, 2, 28);

      // Year wrap on tick and on adjust
      set_date(9999, 12, 31);
      step(1, 3'b000, 3'b000);
      check_date("wrap_tick", 1, 1, 1);
      check("wrap_tick.wrap", int'(bus.wrap), 1);
      step(0, 3'b000, 3'b000);
      check("wrap_after.wrap", int'(bus.wrap), 0);
      press(2, 0);
      check_date("wrap_dec", 9999, 1, 1);
      check("wrap_dec.wrap", int'(bus.wrap), 0);

`ifdef CALENDAR_COUNTER_DOW_EN
      set_date(2024, 1, 1);
      step(0, 3'b000, 3'b000);
      check("dow_2024", int'(bus.dow), 1);
      step(1, 3'b000, 3'b000);
      check("dow_tick", int'(bus.dow), 2);
`endif

      // Reset in the middle of a carrying tick
      set_date(9999, 12, 31);
      chk_en = 0;
      bus.tick = 1'b1;
      #2 rst = 1'b0;
      #1 check_date("rst_async", 2018, 12, 5);
      @(posedge clk);
      #1 check_date("rst_mid_carry", 2018, 12, 5);
      check("rst_mid_carry.wrap", int'(bus.wrap), 0);
      bus.tick = 1'b0;
      model_reset();
      @(negedge clk);
      rst = 1'b1;
      chk_en = 1;
      for (int k = 0; k < 3; k++) step(1, 3'b000, 3'b000);
      check_date("after_rst", 2018, 12, 8);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/calendar_counter.md
CALENDAR_COUNTER -- requirements
Module: calendar_counter

Interface
REQ-001 The block SHALL take parameter YEAR_MIN, default 1, as the lowest legal year.
REQ-002 The block SHALL take parameter YEAR_MAX, default 9999, as the highest legal year.
REQ-003 The block SHALL take parameter YW, default 14, as the year width in bits; 2^YW SHALL exceed YEAR_MAX.
REQ-004 The block SHALL take parameters RST_YEAR, RST_MONTH and RST_DAY, defaults 2018, 12 and 5, as the reset date.
REQ-005 The block SHALL have port clk, input, 1 bit: rising-edge clock.
REQ-006 The block SHALL have port rst, input, 1 bit: reset, asynchronous, active-low.
REQ-007 The block SHALL have port tick, input, 1 bit: one-cycle pulse that advances the date by one day.
REQ-008 The block SHALL have port inc, input, 3 bits: increment buttons {year, month, day}, level-sensitive, synchronous to clk.
REQ-009 The block SHALL have port dec, input, 3 bits: decrement buttons {year, month, day}, same format as inc.
REQ-010 The block SHALL have output day, 5 bits (1..31); output month, 4 bits (1..12); output year, YW bits.
REQ-011 The block SHALL have output leap, 1 bit: the current year is a leap year.
REQ-012 The block SHALL have output dim, 5 bits: number of days in the current month.
REQ-013 The block SHALL have output wrap, 1 bit: one-cycle pulse when the year rolls from YEAR_MAX to YEAR_MIN on a tick.

Function
REQ-014 The block SHALL register all outputs; an update is visible after the same clk edge that samples the event.
REQ-015 The block SHALL set leap = (year%4==0) && (year%100!=0 || year%400==0), Gregorian.
REQ-016 The block SHALL set dim to 31 for months 1, 3, 5, 7, 8, 10 and 12; 30 for months 4, 6, 9 and 11; 29 for month 2 when leap=1, else 28.
REQ-017 On tick, when day<dim, the block SHALL increment day; otherwise day SHALL become 1 and month SHALL increment.
REQ-018 On a tick-driven month carry from 12, month SHALL become 1 and year SHALL increment; from YEAR_MAX, year SHALL become YEAR_MIN and wrap SHALL assert for one cycle.
REQ-019 The block SHALL register each inc/dec bit; an adjust event SHALL fire on a release (previous=1, current=0), once per press.
REQ-020 A day adjust SHALL wrap inside the month (dim to 1 on inc, 1 to dim on dec) and SHALL NOT carry into month.
REQ-021 A month adjust SHALL wrap 12<->1 and SHALL NOT carry into year.
REQ-022 A year adjust SHALL wrap YEAR_MAX<->YEAR_MIN; wrap SHALL NOT assert on a year adjust.
REQ-023 After a month or year adjust, if day exceeds the new dim, day SHALL clamp to the new dim in the same update.
REQ-024 When tick and a release coincide, tick SHALL take effect and all release events in that cycle SHALL be dropped.
REQ-025 At most one adjust SHALL apply per cycle, with priority year > month > day and inc > dec within a field; lower-priority events in that cycle SHALL be dropped.
REQ-026 The outputs SHALL never present an illegal date (day>dim, month outside 1..12, year outside YEAR_MIN..YEAR_MAX).

Reset
REQ-027 While rst=0, the block SHALL force day=RST_DAY, month=RST_MONTH, year=RST_YEAR, wrap=0, and clear the button history, independent of clk.
REQ-028 A button held through reset deassertion SHALL NOT generate an event until it is pressed again.
REQ-029 Reset asserted mid-carry SHALL win; no partial update SHALL be visible.

Configuration
REQ-030 With macro CALENDAR_COUNTER_DOW_EN defined, the block SHALL add output dow, 3 bits (0=Sunday..6), and parameter RST_DOW, default 3.
REQ-031 With CALENDAR_COUNTER_DOW_EN defined, dow SHALL advance mod 7 on tick and SHALL be recomputed from the date one cycle after any adjust.
REQ-032 Without CALENDAR_COUNTER_DOW_EN defined, dow and its logic SHALL be absent; all other behaviour SHALL be identical.

Verification
REQ-033 Reset, then ticks: 2018-12-05 plus 27 ticks -> 2019-01-01; wrap stays 0.
REQ-034 Leap rollover: 2000-02-28 tick -> 02-29; 1900-02-28 tick -> 03-01; 2100-02-28 tick -> 03-01.
REQ-035 Clamp: 2020-03-31, dec month -> 2020-02-29; then dec year -> 2019-02-28.
REQ-036 Wrap: 9999-12-31 tick -> 0001-01-01 with wrap=1 for exactly one cycle; 0001 dec year -> 9999 with wrap=0.
REQ-037 Collision: tick and inc-day release in the same cycle -> day+1 only; inc-month and dec-day releases together -> month+1 only.
REQ-038 With CALENDAR_COUNTER_DOW_EN defined: set the date to 2024-01-01 -> dow=1 one cycle later; one tick -> dow=2.
